instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PC_RESET_VAL, default 32'h0000_0000: pc value loaded on reset.
REQ-002 Parameter XLEN, default 32: width of pc, imem_addr, imem_rdata and ImmOp.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port imem_req, output, 1: instruction fetch request.
REQ-006 Port imem_addr, output, XLEN: fetch byte address; equals pc.
REQ-007 Port imem_ack, input, 1: fetch complete; imem_rdata valid in the same cycle.
REQ-008 Port imem_rdata, input, XLEN: fetched instruction word.
REQ-009 Ports AD1, AD2, AD3, outputs, 5 each: rs1, rs2 and rd register addresses to the datapath.
REQ-010 Ports WE3, ALUSrc, ALUAdd, outputs, 1 each: register write enable, immediate select and add/subtract control.
REQ-011 Port ImmOp, output, XLEN: sign-extended immediate.
REQ-012 Port EQ, input, 1: datapath equality flag.
REQ-013 Port pc, output, XLEN: current program counter.
REQ-014 Port illegal, output, 1: sticky unsupported-instruction flag.
REQ-015 Port halted, output, 1: sticky halt flag (see Configuration).

Function
REQ-016 The FSM SHALL have states FETCH, EXEC and HALT; HALT exists only under the macro.
- FETCH: imem_req=1 and imem_addr=pc.
- FETCH to EXEC on imem_ack=1; imem_rdata is latched into instr on that edge.
- FETCH holds, with req held high, while ack=0.
- EXEC always returns to FETCH unless a halt condition applies.
REQ-017 With zero-wait memory (ack in the first FETCH cycle), throughput SHALL be one instruction per 2 cycles.
REQ-018 imem_ack SHALL be ignored outside FETCH.
REQ-019 Datapath outputs SHALL be driven from instr only in EXEC. In every other state: WE3=0, ALUSrc=0, ALUAdd=0, AD1=AD2=AD3=0, ImmOp=0.
REQ-020 addi (opcode 0010011, funct3 000) in EXEC SHALL drive:
- AD1=instr[19:15] and AD3=instr[11:7];
- ALUSrc=1 and ALUAdd=1;
- ImmOp=sign-extended instr[31:20];
- WE3=1 for exactly that one cycle, and WE3=0 if rd==0;
- pc update at end of EXEC: pc+4.
REQ-021 bne (opcode 1100011, funct3 001) in EXEC SHALL drive:
- AD1=instr[19:15] and AD2=instr[24:20];
- ALUSrc=0, ALUAdd=0 and WE3=0;
- ImmOp=sign-extended B-immediate {instr[31],instr[7],instr[30:25],instr[11:8],1'b0};
- EQ is sampled in EXEC: EQ=0 gives pc+ImmOp, EQ=1 gives pc+4.
REQ-022 Any other encoding in EXEC SHALL set illegal=1 (sticky until reset), keep WE3=0 and advance pc+4.
REQ-023 pc arithmetic SHALL be modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0 silently.
REQ-024 pc SHALL change only at the edge ending EXEC.

Reset
REQ-025 rst_n=0 SHALL immediately force the following, independent of clk:
- state=FETCH and pc=PC_RESET_VAL;
- instr=0, illegal=0 and halted=0;
- imem_req=0 and all datapath outputs at their REQ-019 defaults.
REQ-026 imem_req SHALL rise on the first clk edge after rst_n deasserts.
REQ-027 A reset during a pending fetch SHALL abandon it; a late ack is ignored.

Configuration
REQ-028 Macro SEQ_HALT_DETECT_EN, when defined:
- a taken bne with B-immediate==0 (self-loop) SHALL set halted=1;
- the FSM SHALL enter HALT and hold it until reset;
- in HALT, imem_req=0 and the REQ-019 defaults apply.
REQ-029 Without SEQ_HALT_DETECT_EN: halted is tied 0, the HALT state is absent, and a self-loop refetches the same pc indefinitely.

Structure
REQ-030 Package seq_pkg SHALL hold:
- opcode constants OP_ADDI and OP_BRANCH;
- funct3 constants F3_ADD and F3_BNE;
- the state enum type.
REQ-031 Sub-module imm_gen SHALL perform combinational I- and B-immediate extraction and sign extension; all other logic is in instr_sequencer.

Verification
REQ-032 Reset then addi x10,x0,5 (32'h00500513) with ack in the same cycle. Required in EXEC: AD3=10, AD1=0, ALUSrc=1, ALUAdd=1, ImmOp=5, WE3=1 for one cycle. Then pc=4.
REQ-033 bne x10,x0,-4 (32'hFE051EE3) at pc=8:
- with EQ=0, next pc=4;
- rerun with EQ=1, next pc=12;
- WE3=0 in both cases.
REQ-034 Hold imem_ack=0 for 3 cycles. Required: imem_req and imem_addr stable, no output change, instruction executes one cycle after ack.
REQ-035 Word 32'h00000033 (unsupported). Required: illegal=1 stays set, WE3 never asserted, pc advances by 4.
REQ-036 Assert rst_n=0 mid-fetch at pc=0x40. Required: imem_req drops with no clock, pc=PC_RESET_VAL. Under SEQ_HALT_DETECT_EN, bne x0,x1,0 (32'h00101063) with EQ=0 gives halted=1 and imem_req=0 thereafter.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared decode constants and the FSM state type for the
// instruction sequencer. All three states are listed here. HALT is only
// reachable when the design is built with SEQ_HALT_DETECT_EN.
package seq_pkg;

    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate extraction for the sequencer.
//   instr  [31:0]     in   latched instruction word
//   imm_i  [XLEN-1:0] out  sign-extended I-type immediate instr[31:20]
//   imm_b  [XLEN-1:0] out  sign-extended B-type branch offset (bit 0 = 0)
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_b
);

    // Opcode and rs1/funct3 bits carry no immediate information.
    logic unused_fields;
    assign unused_fields = ^{instr[19:12], instr[6:0]};

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: two-cycle fetch/execute controller for addi and bne.
// Optional feature macro: SEQ_HALT_DETECT_EN (halt on a taken bne self-loop).
//   clk, rst_n                 clock, async active-low reset
//   imem_req/addr/ack/rdata    instruction fetch handshake (addr == pc)
//   AD1, AD2, AD3              rs1 / rs2 / rd addresses to the datapath
//   WE3, ALUSrc, ALUAdd        reg write enable, immediate select, add control
//   ImmOp                      sign-extended immediate
//   EQ                         datapath equality flag, sampled in EXEC
//   pc                         current program counter
//   illegal, halted            sticky status flags
//
// state | meaning
// FETCH | request word at pc, wait for imem_ack
// EXEC  | decode latched word, drive datapath, update pc
// HALT  | self-loop detected, idle until reset (SEQ_HALT_DETECT_EN only)
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] PC_RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [4:0]      AD1,
    output logic [4:0]      AD2,
    output logic [4:0]      AD3,
    output logic            WE3,
    output logic            ALUSrc,
    output logic            ALUAdd,
    output logic [XLEN-1:0] ImmOp,
    input  logic            EQ,
    output logic [XLEN-1:0] pc,
    output logic            illegal,
    output logic            halted
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    seq_state_e      state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            illegal_q;
    logic            fetch_en_q;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_b;
    logic            in_exec;
    logic            is_addi;
    logic            is_bne;
    logic [XLEN-1:0] pc_next;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr_q[31:0]),
        .imm_i (imm_i),
        .imm_b (imm_b)
    );

    assign in_exec = (state_q == EXEC);
    assign is_addi = (instr_q[6:0] == OP_ADDI)   && (instr_q[14:12] == F3_ADD);
    assign is_bne  = (instr_q[6:0] == OP_BRANCH) && (instr_q[14:12] == F3_BNE);

    // fetch_en_q keeps the request low until the first edge after reset, so
    // an ack still on the bus from an abandoned fetch cannot be accepted.
    assign imem_req  = (state_q == FETCH) && fetch_en_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign illegal   = illegal_q;

    always_comb begin
        pc_next = pc_q + PC_STEP;
        if (is_bne && !EQ) begin
            pc_next = pc_q + imm_b;
        end
    end

    always_comb begin
        AD1    = '0;
        AD2    = '0;
        AD3    = '0;
        WE3    = 1'b0;
        ALUSrc = 1'b0;
        ALUAdd = 1'b0;
        ImmOp  = '0;
        if (in_exec && is_addi) begin
            AD1    = instr_q[19:15];
            AD3    = instr_q[11:7];
            WE3    = (instr_q[11:7] != 5'd0);
            ALUSrc = 1'b1;
            ALUAdd = 1'b1;
            ImmOp  = imm_i;
        end else if (in_exec && is_bne) begin
            AD1   = instr_q[19:15];
            AD2   = instr_q[24:20];
            ImmOp = imm_b;
        end
    end

`ifdef SEQ_HALT_DETECT_EN
    logic halted_q;
    logic self_loop;

    assign self_loop = is_bne && !EQ && (imm_b == '0);
    assign halted    = halted_q;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= PC_RESET_VAL;
            instr_q    <= '0;
            illegal_q  <= 1'b0;
            fetch_en_q <= 1'b0;
`ifdef SEQ_HALT_DETECT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            fetch_en_q <= 1'b1;
            case (state_q)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    pc_q <= pc_next;
                    if (!is_addi && !is_bne) begin
                        illegal_q <= 1'b1;
                    end
`ifdef SEQ_HALT_DETECT_EN
                    if (self_loop) begin
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        state_q <= FETCH;
                    end
`else
                    state_q <= FETCH;
`endif
                end
`ifdef SEQ_HALT_DETECT_EN
                HALT:    state_q <= HALT;
`endif
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [4:0]  AD1, AD2, AD3;
    logic        WE3, ALUSrc, ALUAdd;
    logic [31:0] ImmOp;
    logic        EQ;
    logic [31:0] pc;
    logic        illegal;
    logic        halted;

`ifdef SEQ_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    instr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .AD1        (AD1),
        .AD2        (AD2),
        .AD3        (AD3),
        .WE3        (WE3),
        .ALUSrc     (ALUSrc),
        .ALUAdd     (ALUAdd),
        .ImmOp      (ImmOp),
        .EQ         (EQ),
        .pc         (pc),
        .illegal    (illegal),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] m_pc;
    bit          m_illegal;
    bit          m_halted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference immediates computed arithmetically from the instruction word.
    function automatic logic [31:0] ref_imm_i(input logic [31:0] w);
        int v;
        v = int'(w) >>> 20;
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_imm_b(input logic [31:0] w);
        int v;
        v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0});
        if (v >= 4096) v = v - 8192;
        return 32'(v);
    endfunction

    function automatic logic [31:0] mk_addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        logic [11:0] i12;
        i12 = 12'(imm);
        return {i12, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] mk_bne(input logic [4:0] rs1, input logic [4:0] rs2, input int imm);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], rs2, rs1, 3'b001, b[4:1], b[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] mk_illegal();
        logic [31:0] w;
        w = $urandom;
        if (w[6:0] == 7'b0010011 || w[6:0] == 7'b1100011) w[6:0] = 7'b0110011;
        return w;
    endfunction

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 after EXEC.
    task automatic do_instr(input logic [31:0] w, input bit eq, input int waits);
        bit          is_addi, is_bne;
        logic [31:0] e_imm;
        for (int i = 0; i < waits; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            chk("wait_req",  imem_req,  1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_we3",  WE3,       0);
            chk("wait_imm",  ImmOp,     0);
            @(posedge clk); #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        chk("fetch_req",  imem_req,  1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_we3",  WE3,       0);
        @(posedge clk); #1;
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        EQ         = eq;
        #1;
        is_addi = (w[6:0] == 7'h13) && (w[14:12] == 3'd0);
        is_bne  = (w[6:0] == 7'h63) && (w[14:12] == 3'd1);
        e_imm   = is_addi ? ref_imm_i(w) : (is_bne ? ref_imm_b(w) : 32'd0);
        chk("exec_req",    imem_req, 0);
        chk("exec_pc",     pc,       m_pc);
        chk("exec_ad1",    AD1,      (is_addi || is_bne) ? w[19:15] : 5'd0);
        chk("exec_ad2",    AD2,      is_bne ? w[24:20] : 5'd0);
        chk("exec_ad3",    AD3,      is_addi ? w[11:7] : 5'd0);
        chk("exec_we3",    WE3,      is_addi && (w[11:7] != 5'd0));
        chk("exec_alusrc", ALUSrc,   is_addi);
        chk("exec_aluadd", ALUAdd,   is_addi);
        chk("exec_imm",    ImmOp,    e_imm);
        if (is_bne && !eq) begin
            if (HALT_EN && e_imm == 32'd0) m_halted = 1'b1;
            m_pc = m_pc + e_imm;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        if (!is_addi && !is_bne) m_illegal = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("post_pc",      pc,       m_pc);
        chk("post_illegal", illegal,  m_illegal);
        chk("post_halted",  halted,   m_halted);
        chk("post_req",     imem_req, !m_halted);
        chk("post_we3",     WE3,      0);
    endtask

    initial begin
        logic [31:0] w;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        EQ         = 1'b0;
        m_pc       = 32'h0;
        m_illegal  = 1'b0;
        m_halted   = 1'b0;

        #1;
        chk("rst_req",     imem_req, 0);
        chk("rst_pc",      pc,       0);
        chk("rst_illegal", illegal,  0);
        chk("rst_halted",  halted,   0);
        #11;
        rst_n = 1'b1;
        #1;
        chk("rel_req_low", imem_req, 0);
        @(posedge clk); #1;
        chk("rel_req_rise", imem_req, 1);

        // addi x10,x0,5, then bne at pc=8 both ways
        do_instr(32'h00500513, 1'b0, 0);
        chk("addi_pc4", pc, 32'd4);
        do_instr(mk_addi(5'd1, 5'd0, 1), 1'b0, 0);
        do_instr(32'hFE051EE3, 1'b0, 0);
        chk("bne_taken_pc", pc, 32'd4);
        do_instr(mk_addi(5'd0, 5'd3, -7), 1'b0, 0);
        do_instr(32'hFE051EE3, 1'b1, 0);
        chk("bne_fall_pc", pc, 32'd12);

        // wait states, unsupported word, pc wrap
        do_instr(mk_addi(5'd7, 5'd2, -2048), 1'b0, 3);
        do_instr(32'h00000033, 1'b0, 1);
        do_instr(mk_addi(5'd4, 5'd4, 2047), 1'b0, 0);
        chk("illegal_sticky", illegal, 1);
        do_instr(mk_bne(5'd1, 5'd2, -int'(m_pc) - 4), 1'b0, 0);
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        do_instr(mk_addi(5'd5, 5'd6, 3), 1'b0, 0);
        chk("wrap_zero", pc, 32'h0);

        // randomized mix against the model
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0: w = mk_addi(5'($urandom), 5'($urandom), int'($urandom_range(0, 4095)) - 2048);
                1: w = mk_bne(5'($urandom), 5'($urandom),
                              2 * int'($urandom_range(1, 2047)) * ($urandom_range(0, 1) == 1 ? 1 : -1));
                default: w = mk_illegal();
            endcase
            do_instr(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        // reset, then walk to pc=0x40 with straight-line code
        #2;
        rst_n = 1'b0;
        m_pc = 32'h0; m_illegal = 1'b0; m_halted = 1'b0;
        #1;
        chk("rst2_pc", pc, 0);
        chk("rst2_illegal", illegal, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 16; n++) begin
            w = ($urandom_range(0, 1) == 1) ? mk_addi(5'($urandom), 5'($urandom), int'($urandom_range(0, 4095)) - 2048)
                                            : mk_illegal();
            do_instr(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end
        chk("at_0x40", pc, 32'h40);

        // abandon a pending fetch with an asynchronous reset
        imem_ack = 1'b0;
        chk("mid_req_before", imem_req, 1);
        #3;
        rst_n = 1'b0;
        m_pc = 32'h0; m_illegal = 1'b0; m_halted = 1'b0;
        #1;
        chk("mid_req_drop", imem_req, 0);
        chk("mid_pc",       pc,       0);
        chk("mid_illegal",  illegal,  0);
        chk("mid_we3",      WE3,      0);
        chk("mid_ad1",      AD1,      0);
        imem_ack   = 1'b1;
        imem_rdata = mk_addi(5'd9, 5'd0, 1);
        @(posedge clk); #1;
        chk("mid_hold_req", imem_req, 0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("late_ack_req_low", imem_req, 0);
        @(posedge clk); #1;
        chk("late_ack_ignored", imem_req, 1);
        chk("late_ack_pc",      pc,       0);
        imem_ack = 1'b0;

        // bne x0,x1,0 not-equal: halt under the macro, refetch otherwise
        do_instr(32'h00101063, 1'b0, 0);
        chk("selfloop_pc", pc, 32'h0);
        if (HALT_EN) begin
            for (int i = 0; i < 3; i++) begin
                imem_ack = 1'b1;
                @(posedge clk); #1;
                chk("halt_req",    imem_req, 0);
                chk("halt_flag",   halted,   1);
                chk("halt_pc",     pc,       0);
                chk("halt_we3",    WE3,      0);
            end
            imem_ack = 1'b0;
        end else begin
            do_instr(32'h00101063, 1'b0, 1);
            chk("refetch_halted", halted, 0);
            do_instr(mk_addi(5'd2, 5'd0, 8), 1'b0, 0);
            chk("refetch_pc", pc, 32'h4);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
